// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock.
// Start/done handshake shared with the sequential multiplier.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH:0]   acc, acc_shift, trial, acc_nxt;
    logic [WIDTH-1:0] q_reg, q_nxt, m_reg;
    logic [CW-1:0]    count;
    logic             accept, accept_zero, last_iter;

    // Next-state decode and accept/finish strobes
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        accept_zero = 1'b0;
        last_iter   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        accept_zero = 1'b1;
                        state_nxt   = DONE;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = DIVIDE;
                    end
                end
            end
            DIVIDE: begin
                if (count == CNT_ONE) begin
                    last_iter = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One shift/trial-subtract step of the restoring algorithm
    always_comb begin
        acc_shift = {acc[WIDTH-1:0], q_reg[WIDTH-1]};
        trial     = acc_shift - {1'b0, m_reg};
        acc_nxt   = acc_shift;
        q_nxt     = {q_reg[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            acc_nxt = trial;
            q_nxt   = {q_reg[WIDTH-2:0], 1'b1};
        end
    end

    // State register with registered busy/done flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == DIVIDE);
            done  <= (state_nxt == DONE);
        end
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc         <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            acc         <= '0;
            q_reg       <= dividend;
            m_reg       <= divisor;
            count       <= CNT_INIT;
            div_by_zero <= 1'b0;
        end else if (accept_zero) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
        end else if (state == DIVIDE) begin
            acc   <= acc_nxt;
            q_reg <= q_nxt;
            count <= count - CNT_ONE;
            if (last_iter) begin
                quotient  <= q_nxt;
                remainder <= acc_nxt[WIDTH-1:0];
            end
        end
    end

endmodule
